// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Merges ALU and load write-backs into the single write port of the 8x8
// register file. Loads that cannot go out immediately wait in a small FIFO.
// A starvation counter forces the FIFO head out after STARVE_LIMIT
// consecutive ALU wins.
// Optional feature macro: WB_PENDING_QUERY_EN adds query_reg/query_pending,
// a combinational hazard check against queued and staged writes.
module regfile_wb_arbiter #(
    parameter int LQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic [2:0] alu_reg,
    input  logic [7:0] alu_data,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [2:0] load_reg,
    input  logic [7:0] load_data,
    output logic       regWrite,
    output logic [2:0] writeReg,
    output logic [7:0] writeData
`ifdef WB_PENDING_QUERY_EN
    ,
    input  logic [2:0] query_reg,
    output logic       query_pending
`endif
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);
    localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

    // FIFO storage: data is read only at the head, register tags are also
    // scanned by the optional hazard query.
    logic [7:0] r_data_mem [LQ_DEPTH];
    logic [2:0] r_reg_mem  [LQ_DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_starve;

    logic w_nonempty;
    logic w_alu_fire;
    logic w_load_fire;
    logic w_pop;
    logic w_bypass;
    logic w_push;
    logic w_starve_block;

    assign w_nonempty     = (r_count != '0);
    assign w_starve_block = w_nonempty && (r_starve == LIMIT_C);

    assign load_ready = !rst && (r_count < DEPTH_C);
    assign alu_ready  = !rst && !w_starve_block;

    assign w_alu_fire  = alu_valid && alu_ready;
    assign w_load_fire = load_valid && load_ready;

    // ALU has priority, then the FIFO head, then a direct load bypass.
    assign w_pop    = !w_alu_fire && w_nonempty;
    assign w_bypass = !w_alu_fire && !w_nonempty && w_load_fire;
    assign w_push   = w_load_fire && !w_bypass;

    // FIFO tail write; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= load_data;
            r_reg_mem[r_wr_ptr]  <= load_reg;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: counts ALU wins over a waiting load, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (!w_nonempty || w_pop) begin
            r_starve <= '0;
        end else if (w_alu_fire && (r_starve != LIMIT_C)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Registered write port toward the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else if (w_alu_fire) begin
            regWrite  <= 1'b1;
            writeReg  <= alu_reg;
            writeData <= alu_data;
        end else if (w_pop) begin
            regWrite  <= 1'b1;
            writeReg  <= r_reg_mem[r_rd_ptr];
            writeData <= r_data_mem[r_rd_ptr];
        end else if (w_bypass) begin
            regWrite  <= 1'b1;
            writeReg  <= load_reg;
            writeData <= load_data;
        end else begin
            regWrite  <= 1'b0;
        end
    end

`ifdef WB_PENDING_QUERY_EN
    logic [LQ_DEPTH-1:0] w_hit;

    // One comparator per FIFO slot; a slot is live when its distance from
    // the read pointer is below the current occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < LQ_DEPTH; gi = gi + 1) begin : g_query
            localparam logic [PW-1:0] IDX = PW'(gi);
            logic [PW-1:0] w_offset;
            assign w_offset  = IDX - r_rd_ptr;
            assign w_hit[gi] = ({1'b0, w_offset} < r_count) &&
                               (r_reg_mem[gi] == query_reg);
        end
    endgenerate

    assign query_pending = !rst &&
                           ((|w_hit) || (regWrite && (writeReg == query_reg)));
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed stimulus with a write
// scoreboard; expected writes carry the cycle they must appear in.
module tb_regfile_wb_arbiter;

    logic       clk;
    logic       rst;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] alu_reg;
    logic [7:0] alu_data;
    logic       load_valid;
    logic       load_ready;
    logic [2:0] load_reg;
    logic [7:0] load_data;
    logic       regWrite;
    logic [2:0] writeReg;
    logic [7:0] writeData;
`ifdef WB_PENDING_QUERY_EN
    logic [2:0] query_reg;
    logic       query_pending;
`endif

    regfile_wb_arbiter #(.LQ_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_reg   (load_reg),
        .load_data  (load_data),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData)
`ifdef WB_PENDING_QUERY_EN
        ,
        .query_reg     (query_reg),
        .query_pending (query_pending)
`endif
    );

    typedef struct {
        int         cyc;
        logic [2:0] r;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  cyc     = 0;
    int  n_pass  = 0;
    int  n_total = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Apply one cycle of inputs just after the falling edge.
    task automatic drive(input logic av, input logic [2:0] ar, input logic [7:0] ad,
                         input logic lv, input logic [2:0] lr, input logic [7:0] ld);
        @(negedge clk);
        alu_valid  = av;
        alu_reg    = ar;
        alu_data   = ad;
        load_valid = lv;
        load_reg   = lr;
        load_data  = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    endtask

    // Expect a write dly cycles after the current one.
    task automatic expw(input int dly, input logic [2:0] r, input logic [7:0] d);
        exp_q.push_back(wr_t'{cyc + dly, r, d});
    endtask

    // Monitor: every write must match the scoreboard head, in order and cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (regWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got r%0d=%0h at cycle %0d, required no write",
                             writeReg, writeData, cyc);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_reg", 32'(writeReg), 32'(e.r));
                    chk("wr_data", 32'(writeData), 32'(e.d));
                    $display("write cycle %0d r%0d=%02h", cyc, writeReg, writeData);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                wr_t e;
                e = exp_q.pop_front();
                n_total++;
                $display("FAIL missing_write: got regWrite=%b at cycle %0d, required r%0d=%0h",
                         regWrite, cyc, e.r, e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        alu_valid  = 1'b1;
        alu_reg    = 3'd7;
        alu_data   = 8'hFF;
        load_valid = 1'b1;
        load_reg   = 3'd6;
        load_data  = 8'hEE;
`ifdef WB_PENDING_QUERY_EN
        query_reg  = 3'd0;
`endif

        // Reset held two cycles with both requests active.
        @(negedge clk); #1;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        @(negedge clk); #1;
        chk("rst_alu_ready2", 32'(alu_ready), 32'd0);
        chk("rst_load_ready2", 32'(load_ready), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_writeReg", 32'(writeReg), 32'd0);
        chk("rst_writeData", 32'(writeData), 32'd0);
`ifdef WB_PENDING_QUERY_EN
        chk("rst_query_pending", 32'(query_pending), 32'd0);
`endif
        rst        = 1'b0;
        alu_valid  = 1'b0;
        load_valid = 1'b0;
        idle();
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("post_rst_load_ready", 32'(load_ready), 32'd1);

        // Bypass of a load into an empty FIFO.
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'hA7);
        chk("byp_load_ready", 32'(load_ready), 32'd1);
        expw(1, 3'd5, 8'hA7);
        idle();
        chk("byp_alu_ready", 32'(alu_ready), 32'd1);
        idle();

        // Collision: ALU wins, load is buffered and follows.
        drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
        chk("col_alu_ready", 32'(alu_ready), 32'd1);
        chk("col_load_ready", 32'(load_ready), 32'd1);
        expw(1, 3'd1, 8'h11);
        expw(2, 3'd2, 8'h22);
        idle();
        idle();
        idle();

        // Starvation: r3 buffered, ALU streams; three wins then a forced pop.
        drive(1'b1, 3'd0, 8'h01, 1'b1, 3'd3, 8'h33);
        expw(1, 3'd0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'(4 + i), 8'(8'h40 + i), 1'b0, 3'd0, 8'h00);
            chk("stv_alu_ready", 32'(alu_ready), 32'd1);
            expw(1, 3'(4 + i), 8'(8'h40 + i));
        end
        drive(1'b1, 3'd7, 8'h50, 1'b0, 3'd0, 8'h00);
        chk("stv_blocked", 32'(alu_ready), 32'd0);
        expw(1, 3'd3, 8'h33);
        drive(1'b1, 3'd7, 8'h50, 1'b0, 3'd0, 8'h00);
        chk("stv_resume", 32'(alu_ready), 32'd1);
        expw(1, 3'd7, 8'h50);
        idle();
        idle();

        // Full FIFO: four loads buffered behind ALU traffic.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 8'(8'h60 + i), 1'b1, 3'(4 + i), 8'(8'h80 + i));
            chk("full_fill_load_ready", 32'(load_ready), 32'd1);
            chk("full_fill_alu_ready", 32'(alu_ready), 32'd1);
            expw(1, 3'd1, 8'(8'h60 + i));
        end
        drive(1'b1, 3'd1, 8'h64, 1'b1, 3'd0, 8'h99);
        chk("full_load_ready", 32'(load_ready), 32'd0);
        chk("full_alu_blocked", 32'(alu_ready), 32'd0);
        expw(1, 3'd4, 8'h80);
        drive(1'b1, 3'd1, 8'h64, 1'b0, 3'd0, 8'h00);
        chk("full_load_ready_back", 32'(load_ready), 32'd1);
        chk("full_alu_ready_back", 32'(alu_ready), 32'd1);
        expw(1, 3'd1, 8'h64);
        for (int i = 1; i < 4; i++) begin
            idle();
            expw(1, 3'(4 + i), 8'(8'h80 + i));
        end
        idle();
        idle();

        // Reset mid-stream discards the buffered load.
        drive(1'b1, 3'd2, 8'h12, 1'b1, 3'd3, 8'h34);
        expw(1, 3'd2, 8'h12);
        drive(1'b1, 3'd2, 8'h56, 1'b1, 3'd3, 8'h78);
        rst = 1'b1;
        #1;
        chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("mid_rst_load_ready", 32'(load_ready), 32'd0);
        idle();
        rst = 1'b0;
        chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
        chk("mid_rst_writeReg", 32'(writeReg), 32'd0);
        chk("mid_rst_writeData", 32'(writeData), 32'd0);
        idle();
        idle();
        idle();

`ifdef WB_PENDING_QUERY_EN
        // Hazard query against FIFO contents and the staged write.
        drive(1'b1, 3'd1, 8'h01, 1'b1, 3'd6, 8'h66);
        expw(1, 3'd1, 8'h01);
        drive(1'b1, 3'd1, 8'h02, 1'b0, 3'd0, 8'h00);
        expw(1, 3'd1, 8'h02);
        query_reg = 3'd6; #1;
        chk("qry_fifo_hit", 32'(query_pending), 32'd1);
        query_reg = 3'd4; #1;
        chk("qry_miss", 32'(query_pending), 32'd0);
        query_reg = 3'd1; #1;
        chk("qry_outreg_hit", 32'(query_pending), 32'd1);
        drive(1'b1, 3'd1, 8'h03, 1'b0, 3'd0, 8'h00);
        expw(1, 3'd1, 8'h03);
        drive(1'b1, 3'd1, 8'h04, 1'b0, 3'd0, 8'h00);
        expw(1, 3'd1, 8'h04);
        idle();
        expw(1, 3'd6, 8'h66);
        idle();
        query_reg = 3'd6; #1;
        chk("qry_staged_r6", 32'(query_pending), 32'd1);
        idle();
        chk("qry_retired_r6", 32'(query_pending), 32'd0);
        idle();
`endif

        idle();
        idle();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
